ps2_keycode_rx: RTL and testbench
=================================

# ps2_keycode_rx

PS/2 keyboard receiver producing the 16-bit `keycode` word consumed by the game/VGA top level. Synchronises and deglitches the raw PS/2 clock/data pins, deframes 11-bit device-to-host frames, checks start/parity/stop, and shifts each good byte into a two-byte history register. The result is `{previous_byte, latest_byte}`, so a break sequence appears as `0xF0xx`.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronised samples required before the filtered PS/2 clock changes (≥2).
- `TIMEOUT_CYCLES`, 65000: `clk` cycles without a filtered falling edge, while mid-frame, before the frame is aborted (≈1 ms at 65 MHz).
- `clk`  in  1  system clock; sole clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `keycode`  out  16  `{previous good byte, latest good byte}`.
- `key_strobe`  out  1  one-cycle pulse when `keycode` is updated.
- `frame_err`  out  1  one-cycle pulse on a rejected or aborted frame.

## Operation
- Both pins pass through 2-FF synchronisers. Synchroniser reset value is 1, the PS/2 idle level.
- Clock filter:
  - A counter increments while the synchronised clock differs from filtered `clk_f`, and clears when they are equal.
  - When the counter reaches `FILTER_LEN`, `clk_f` takes the synchronised value and the counter clears.
  - A falling edge of `clk_f` produces internal `fall` for one cycle.
- Data is sampled only on `fall`, from the synchronised data line.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), go to DATA and clear the bit counter. On `fall` with data=1, stay in IDLE with no error.
  - DATA: on each `fall`, shift the bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, capture the parity bit and go to STOP.
  - STOP: on `fall`, the frame is good when stop=1 and the 9 bits (data + parity) contain an odd number of ones.
    - Good frame: `keycode <= {keycode[7:0], byte}` and `key_strobe` pulses.
    - Bad frame: `frame_err` pulses and `keycode` is held.
    - Either way, return to IDLE.
- Timeout:
  - The idle counter clears on every `fall` and in IDLE; it increments otherwise.
  - On reaching `TIMEOUT_CYCLES` in DATA, PARITY or STOP: return to IDLE, pulse `frame_err`, discard the partial byte.
- No dedicated make/break decoding; `0xE0`/`0xF0` prefixes are ordinary bytes.
- Receive only; the block never drives the PS/2 lines.

## Timing
- Reset values: `keycode`=0x0000, `key_strobe`=0, `frame_err`=0, state IDLE, `clk_f`=1, all counters 0.
- Pin-to-`fall` latency: 2 synchroniser cycles + `FILTER_LEN` cycles after the pin settles low.
- `key_strobe` and the new `keycode` value appear in the cycle after the `fall` that samples the stop bit. `keycode` then stays stable until the next good frame.
- `key_strobe` and `frame_err` are never high together. Each pulse is exactly 1 cycle.
- Pin pulses shorter than `FILTER_LEN` cycles (after synchronisation) never change `clk_f`.
- `rst` mid-frame: the next cycle is IDLE with reset values. The remaining bits of the interrupted frame are dropped without an error:
  - Data bits are 1 → ignored in IDLE.
  - A 0 bit → starts a new frame, which times out or fails its checks.
- Timeout check and `fall` in the same cycle: `fall` wins and the counter clears.

## Test plan
- Reset: hold `rst` 5 cycles with pins high → `keycode`=0x0000, no strobes/errors for 1000 cycles.
- Good frame 0x1D (bits LSB-first, parity=1, stop=1), PS/2 half-period 2000 cycles → exactly one `key_strobe`, `keycode`=0x001D; then send 0xF0, 0x1D → `keycode` reads 0x1DF0, then 0xF01D, with one strobe each.
- Byte 0x1C sent with parity=1 (wrong) → one `frame_err`, no strobe, `keycode` unchanged. Repeat with stop=0 → same response.
- 3-cycle low glitches on `ps2_clk` every 100 cycles with `FILTER_LEN`=8 → no `fall`, no state change. Then send a good 0x29 frame → `keycode` low byte 0x29.
- Abort after start + 4 data bits, pins idle high → `frame_err` exactly `TIMEOUT_CYCLES` cycles after the last `fall` (±1). A following good frame 0x75 is received correctly.
- Assert `rst` 1 cycle mid-DATA of a frame whose remaining bits are 1 → `keycode`=0x0000, no error. The next good frame 0x6B gives `keycode`=0x006B.

Source files
------------

// File: rtl/ps2_keycode_rx.sv
// rtl/ps2_keycode_rx.sv - PS/2 keyboard receiver producing {previous, latest} keycode bytes
module ps2_keycode_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 65000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] keycode,
   output logic        key_strobe,
   output logic        frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
   logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
   logic          clk_f_q, clk_f_d;
   logic [FW-1:0] flt_cnt_q, flt_cnt_d;
   logic          fall_q, fall_d;
   logic [1:0]    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [15:0]   keycode_q, keycode_d;
   logic          strobe_q, strobe_d;
   logic          err_q, err_d;
   logic [TW-1:0] idle_cnt_q, idle_cnt_d;

   always_comb begin
      clk_s1_d = ps2_clk;
      clk_s2_d = clk_s1_q;
      dat_s1_d = ps2_data;
      dat_s2_d = dat_s1_q;

      // Filtered clock only follows the pin after FILTER_LEN consecutive differing samples
      clk_f_d   = clk_f_q;
      flt_cnt_d = '0;
      if (clk_s2_q != clk_f_q) begin
         if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
            clk_f_d = clk_s2_q;
         end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
         end
      end
      fall_d = clk_f_q & ~clk_f_d;

      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      keycode_d  = keycode_q;
      strobe_d   = 1'b0;
      err_d      = 1'b0;
      idle_cnt_d = (fall_q || state_q == S_IDLE) ? '0 : idle_cnt_q + 1'b1;

      if (fall_q) begin
         case (state_q)
            S_IDLE: begin
               if (!dat_s2_q) begin
                  state_d   = S_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            S_DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               par_d   = dat_s2_q;
               state_d = S_STOP;
            end
            default: begin
               if (dat_s2_q && (^{shift_q, par_q})) begin
                  keycode_d = {keycode_q[7:0], shift_q};
                  strobe_d  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = S_IDLE;
            end
         endcase
      end else if (state_q != S_IDLE && idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
         // Stalled mid-frame: drop the partial byte
         state_d = S_IDLE;
         shift_d = '0;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         clk_f_q    <= 1'b1;
         flt_cnt_q  <= '0;
         fall_q     <= 1'b0;
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         keycode_q  <= '0;
         strobe_q   <= 1'b0;
         err_q      <= 1'b0;
         idle_cnt_q <= '0;
      end else begin
         clk_s1_q   <= clk_s1_d;
         clk_s2_q   <= clk_s2_d;
         dat_s1_q   <= dat_s1_d;
         dat_s2_q   <= dat_s2_d;
         clk_f_q    <= clk_f_d;
         flt_cnt_q  <= flt_cnt_d;
         fall_q     <= fall_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         keycode_q  <= keycode_d;
         strobe_q   <= strobe_d;
         err_q      <= err_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   assign keycode    = keycode_q;
   assign key_strobe = strobe_q;
   assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb/tb_ps2_keycode_rx.sv - randomized self-checking bench for ps2_keycode_rx
module tb_ps2_keycode_rx;

   localparam int FL   = 8;
   localparam int TO   = 3000;
   localparam int HALF = 120;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [15:0] keycode;
   logic        key_strobe;
   logic        frame_err;

   int checks = 0;
   int failures = 0;
   int n_strobe = 0;
   int n_err = 0;
   int viol = 0;
   logic prev_strobe = 1'b0;
   logic prev_err = 1'b0;
   logic [15:0] exp_kc = 16'h0000;

   ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keycode(keycode), .key_strobe(key_strobe), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_strobe) n_strobe <= n_strobe + 1;
      if (frame_err) n_err <= n_err + 1;
      if ((key_strobe && frame_err) || (key_strobe && prev_strobe) || (frame_err && prev_err))
         viol <= viol + 1;
      prev_strobe <= key_strobe;
      prev_err    <= frame_err;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      send_bit(stop);
      ps2_data = 1'b1;
      wait_cycles(HALF);
   endtask

   // Sends one frame and checks strobe/error counts and keycode against the model
   task automatic frame_and_check(input string name, input logic [7:0] b,
                                  input logic bad_par, input logic stop);
      int s0, e0;
      logic good;
      s0 = n_strobe;
      e0 = n_err;
      good = !bad_par && stop;
      send_frame(b, bad_par, stop);
      if (good) exp_kc = {exp_kc[7:0], b};
      checks++;
      if (keycode !== exp_kc) begin
         failures++;
         $display("FAIL %s keycode: got %h expected %h", name, keycode, exp_kc);
      end
      checks++;
      if ((n_strobe - s0) !== (good ? 1 : 0) || (n_err - e0) !== (good ? 0 : 1)) begin
         failures++;
         $display("FAIL %s pulses: strobes %0d errors %0d, expected %0d and %0d",
                  name, n_strobe - s0, n_err - e0, good ? 1 : 0, good ? 0 : 1);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_cycles(5);
      rst = 1'b0;
      wait_cycles(1);
      checks++;
      if (keycode !== 16'h0000 || key_strobe !== 1'b0 || frame_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: got kc=%h st=%b er=%b expected 0000 0 0",
                  keycode, key_strobe, frame_err);
      end
      wait_cycles(1000);
      checks++;
      if (n_strobe !== 0 || n_err !== 0) begin
         failures++;
         $display("FAIL reset_quiet: got strobes=%0d errors=%0d expected 0 0", n_strobe, n_err);
      end
   endtask

   task automatic test_good_sequence();
      frame_and_check("good_1d", 8'h1D, 1'b0, 1'b1);
      frame_and_check("good_f0", 8'hF0, 1'b0, 1'b1);
      frame_and_check("good_1d_again", 8'h1D, 1'b0, 1'b1);
      checks++;
      if (keycode !== 16'hF01D) begin
         failures++;
         $display("FAIL break_sequence: got %h expected f01d", keycode);
      end
   endtask

   task automatic test_bad_frames();
      frame_and_check("bad_parity", 8'h1C, 1'b1, 1'b1);
      frame_and_check("bad_stop", 8'h1C, 1'b0, 1'b0);
   endtask

   task automatic test_glitch();
      int s0, e0;
      s0 = n_strobe;
      e0 = n_err;
      for (int i = 0; i < 10; i++) begin
         ps2_clk = 1'b0;
         wait_cycles(3);
         ps2_clk = 1'b1;
         wait_cycles(97);
      end
      checks++;
      if (n_strobe !== s0 || n_err !== e0 || keycode !== exp_kc) begin
         failures++;
         $display("FAIL glitch_ignored: got kc=%h strobes+%0d errors+%0d expected %h +0 +0",
                  keycode, n_strobe - s0, n_err - e0, exp_kc);
      end
      frame_and_check("after_glitch_29", 8'h29, 1'b0, 1'b1);
      checks++;
      if (keycode[7:0] !== 8'h29) begin
         failures++;
         $display("FAIL glitch_low_byte: got %h expected 29", keycode[7:0]);
      end
   endtask

   task automatic test_timeout();
      int cnt, s0, e0;
      logic [3:0] bits;
      bits = 4'($urandom);
      s0 = n_strobe;
      e0 = n_err;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(bits[i]);
      ps2_data = bits[3];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      cnt = 0;
      while (frame_err !== 1'b1 && cnt < TO + 500) begin
         @(negedge clk);
         cnt++;
         if (cnt == HALF) begin
            ps2_clk  = 1'b1;
            ps2_data = 1'b1;
         end
      end
      // Pin low -> fall takes 2 + FL cycles; error follows TO cycles after the fall
      checks++;
      if (cnt < TO + FL + 2 - 2 || cnt > TO + FL + 2 + 2) begin
         failures++;
         $display("FAIL timeout_latency: got %0d cycles expected %0d +-2", cnt, TO + FL + 2);
      end
      wait_cycles(5);
      checks++;
      if ((n_err - e0) !== 1 || n_strobe !== s0 || keycode !== exp_kc) begin
         failures++;
         $display("FAIL timeout_pulse: got errors+%0d strobes+%0d kc=%h expected +1 +0 %h",
                  n_err - e0, n_strobe - s0, keycode, exp_kc);
      end
      frame_and_check("after_timeout_75", 8'h75, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid_frame();
      int e0, s0;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rst = 1'b1;
      wait_cycles(1);
      rst = 1'b0;
      exp_kc = 16'h0000;
      e0 = n_err;
      s0 = n_strobe;
      for (int i = 0; i < 7; i++) send_bit(1'b1);
      wait_cycles(HALF);
      checks++;
      if (keycode !== 16'h0000 || n_err !== e0 || n_strobe !== s0) begin
         failures++;
         $display("FAIL reset_mid_frame: got kc=%h errors+%0d strobes+%0d expected 0000 +0 +0",
                  keycode, n_err - e0, n_strobe - s0);
      end
      frame_and_check("after_reset_6b", 8'h6B, 1'b0, 1'b1);
      checks++;
      if (keycode !== 16'h006B) begin
         failures++;
         $display("FAIL reset_then_6b: got %h expected 006b", keycode);
      end
   endtask

   task automatic test_random_frames();
      for (int i = 0; i < 8; i++) begin
         logic [7:0] b;
         int kind;
         b = 8'($urandom);
         kind = $urandom_range(0, 3);
         wait_cycles($urandom_range(0, 200));
         frame_and_check($sformatf("random_%0d", i), b, kind == 2, kind != 3);
      end
   endtask

   task automatic test_pulse_rules();
      checks++;
      if (viol !== 0) begin
         failures++;
         $display("FAIL pulse_rules: got %0d violations expected 0", viol);
      end
   endtask

   initial begin
      test_reset();
      test_good_sequence();
      test_bad_frames();
      test_glitch();
      test_timeout();
      test_reset_mid_frame();
      test_random_frames();
      test_pulse_rules();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
